// File: rtl/cpu_run_monitor.sv
// Run controller and trace monitor for the single-cycle CPU: samples each RUN cycle,
// counts cycles/branches, detects halt/stall/timeout and keeps a circular {pc, instr} trace.
module cpu_run_monitor #(
  parameter int                ADDR_W      = 64,
  parameter int                INSTR_W     = 32,
  parameter int                CNT_W       = 16,
  parameter int                MAX_CYCLES  = 100,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 32'hD503201F,
  parameter int                STALL_LIMIT = 2,
  parameter int                TRACE_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           run_en,
  input  logic                           clear,
  input  logic [ADDR_W-1:0]              pc,
  input  logic [INSTR_W-1:0]             instr,
  input  logic [ADDR_W-1:0]              next_pc,
  input  logic                           branch_taken,
  output logic                           running,
  output logic                           done,
  output logic [1:0]                     done_cause,
  output logic [CNT_W-1:0]               cycle_count,
  output logic [CNT_W-1:0]               branch_count,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx,
  output logic [ADDR_W-1:0]              rd_pc,
  output logic [INSTR_W-1:0]             rd_instr
);
  // state  | meaning
  // S_IDLE | waiting for run_en, nothing sampled
  // S_RUN  | one trace/count sample per edge, termination checked
  // S_DONE | results frozen until clear
  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam int TC_W  = PTR_W + 1;
  localparam int SC_W  = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    state, state_nxt;
  logic [PTR_W-1:0]          wr_ptr;
  logic [SC_W-1:0]           stall_cnt, stall_nxt;
  logic [CNT_W-1:0]          cycle_nxt;
  logic [1:0]                cause_nxt;
  logic [PTR_W-1:0]          rd_phys;
  logic [ADDR_W+INSTR_W-1:0] trace_mem [TRACE_DEPTH];

  always_comb begin
    state_nxt = state;
    cause_nxt = 2'd0;
    stall_nxt = (next_pc == pc) ? stall_cnt + 1'b1 : '0;
    cycle_nxt = cycle_count + 1'b1;
    case (state)
      S_IDLE: if (run_en) state_nxt = S_RUN;
      S_RUN: begin
        // halt outranks stall, which outranks timeout
        if (instr == HALT_INSTR)                     cause_nxt = 2'd1;
        else if (stall_nxt == SC_W'(STALL_LIMIT))    cause_nxt = 2'd2;
        else if (cycle_nxt == CNT_W'(MAX_CYCLES))    cause_nxt = 2'd3;
        if (cause_nxt != 2'd0) state_nxt = S_DONE;
      end
      S_DONE: if (clear) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      stall_cnt    <= '0;
      cycle_count  <= '0;
      branch_count <= '0;
      trace_count  <= '0;
      done_cause   <= 2'd0;
    end else begin
      case (state)
        S_RUN: begin
          wr_ptr       <= wr_ptr + 1'b1;
          stall_cnt    <= stall_nxt;
          cycle_count  <= cycle_nxt;
          branch_count <= branch_count + CNT_W'(branch_taken);
          done_cause   <= cause_nxt;
          if (trace_count != TC_W'(TRACE_DEPTH)) trace_count <= trace_count + 1'b1;
        end
        S_DONE: if (clear) begin
          wr_ptr       <= '0;
          stall_cnt    <= '0;
          cycle_count  <= '0;
          branch_count <= '0;
          trace_count  <= '0;
          done_cause   <= 2'd0;
        end
        default: ;
      endcase
    end
  end

  // trace storage has no reset; trace_count qualifies what is valid
  always_ff @(posedge clk) begin
    if (state == S_RUN) trace_mem[wr_ptr] <= {pc, instr};
  end

  assign rd_phys             = wr_ptr - trace_count[PTR_W-1:0] + rd_idx;
  assign {rd_pc, rd_instr}   = trace_mem[rd_phys];
  assign running             = (state == S_RUN);
  assign done                = (state == S_DONE);
endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
- Synthesizable run controller and trace monitor that sits beside the single-cycle CPU.
- Samples PC, instruction, next PC and branch-taken every cycle while running.
- Counts cycles and taken branches, and detects program completion (halt instruction, PC stall or cycle budget).
- Keeps a circular trace of the last TRACE_DEPTH {pc, instr} pairs, readable after the run.
- Parametrised successor to the fixed-budget bench run loop; usable both in simulation and on board.

Parameters:
ADDR_W, 64, width of pc/next_pc
INSTR_W, 32, instruction width
CNT_W, 16, width of cycle and branch counters
MAX_CYCLES, 100, cycle budget before timeout (1..2^CNT_W-1)
HALT_INSTR, 32'hD503201F, encoding treated as program end
STALL_LIMIT, 2, consecutive non-advancing cycles that mean completion (>=1)
TRACE_DEPTH, 16, trace entries (power of two, >=2)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
run_en  in  1  level; starts the run from IDLE
clear  in  1  synchronous; DONE -> IDLE and counters zeroed
pc  in  ADDR_W  PC of current instruction
instr  in  INSTR_W  current instruction
next_pc  in  ADDR_W  PC the CPU will load next
branch_taken  in  1  current instruction redirects PC
running  out  1  state == RUN
done  out  1  state == DONE
done_cause  out  2  0 none, 1 halt, 2 stall, 3 timeout
cycle_count  out  CNT_W  RUN cycles sampled
branch_count  out  CNT_W  taken branches sampled
trace_count  out  $clog2(TRACE_DEPTH)+1  valid trace entries, saturating
rd_idx  in  $clog2(TRACE_DEPTH)  trace read index, 0 = oldest valid
rd_pc  out  ADDR_W  trace pc at rd_idx (combinational)
rd_instr  out  INSTR_W  trace instr at rd_idx (combinational)

Behaviour:
- Reset (async, any state, including mid-run):
  - state IDLE; running=0, done=0, done_cause=0.
  - cycle_count, branch_count, trace_count, write pointer and stall counter = 0.
  - Trace storage contents need not be cleared.
- States:
  - IDLE: no sampling; -> RUN on the edge where run_en=1.
  - RUN: one sample per rising edge. Sampling starts on the edge after the IDLE->RUN edge.
  - DONE: sticky; all counters and trace frozen; -> IDLE on clear=1 (counters and trace_count zeroed). run_en is ignored in DONE.
- clear is ignored in IDLE and RUN.
- Per RUN edge (single cycle):
  - Write {pc, instr} at the write pointer; pointer increments mod TRACE_DEPTH (wrap overwrites the oldest entry).
  - trace_count increments, saturating at TRACE_DEPTH.
  - cycle_count += 1.
  - branch_count += branch_taken.
  - Stall counter: +1 if next_pc == pc, else 0.
- Termination on that same edge; next state DONE, evaluated in priority order:
  - halt: instr == HALT_INSTR, cause 1.
  - stall: updated stall counter == STALL_LIMIT, cause 2.
  - timeout: updated cycle_count == MAX_CYCLES, cause 3.
  - When several conditions hold together, only the highest-priority cause is reported.
- The terminating sample is traced and counted.
- done and done_cause are registered; both are visible the cycle after the terminating edge.
- Trace read: physical index = (wr_ptr - trace_count + rd_idx) mod TRACE_DEPTH. rd_idx >= trace_count returns don't-care data.
- Counters never wrap: MAX_CYCLES < 2^CNT_W guarantees termination before overflow, and branch_count <= cycle_count.

Test Plan:
- Halt: run_en pulse; PCs 0,4,8 then HALT_INSTR at PC 12 (next_pc 16) -> done=1, cause=1, cycle_count=4, trace_count=4, rd_idx 3 gives pc=12.
- Stall: PCs 0,4, then pc=8 with next_pc=8 twice -> cause=2, cycle_count=4. Variant: a single stall then advancing -> no termination.
- Timeout and wrap: incrementing PCs, no halt, MAX_CYCLES=100 -> cause=3, cycle_count=100, trace_count=16, rd_idx 0 gives pc of sample 85 (pc=336), rd_idx 15 gives pc=396.
- Priority: HALT_INSTR with next_pc==pc on the second stall sample -> cause=1. Halt on sample 100 -> cause=1.
- Branch: 10 samples with branch_taken on 3, then halt -> branch_count=3 (4 if the halt sample also asserts branch_taken).
- Reset/clear: rst asserted mid-run at sample 5, between edges -> outputs 0 immediately, state IDLE. In DONE: clear -> IDLE with zero counters; run_en during DONE leaves all outputs unchanged.
